// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first a programmable number of times,
// with optional zero gap bits between repetitions. Outputs decode from registered state only.
module pattern_tx #(
    parameter int unsigned       PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1101,
    parameter int unsigned       GAP     = 1,
    parameter int unsigned       CNT_W   = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_count,
    input  logic             abort,
    output logic             o,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BIT_W = $clog2(PAT_W);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP == 0) ? 0 : GAP - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rem_d     = rem_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (rep_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        rem_d     = rep_count;
                        shift_d   = PATTERN;
                        bit_cnt_d = '0;
                        state_d   = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    rem_d     = '0;
                    gap_cnt_d = '0;
                end else begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        rem_d     = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_d = S_DONE;
                        end else if (GAP != 0) begin
                            gap_cnt_d = '0;
                            state_d   = S_GAP;
                        end else begin
                            // Back-to-back: reload so the next MSB follows without a bubble.
                            shift_d = PATTERN;
                        end
                    end
                end
            end

            S_GAP: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    rem_d     = '0;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == LAST_GAP) begin
                    gap_cnt_d = '0;
                    shift_d   = PATTERN;
                    state_d   = S_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rem_q     <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rem_q     <= rem_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign o         = (state_q == S_SHIFT) && shift_q[PAT_W-1];
    assign bit_valid = (state_q == S_SHIFT);
    assign busy      = (state_q == S_SHIFT) || (state_q == S_GAP);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: instance a uses one gap bit, instance b sends back-to-back.
// Expected per-cycle {o, bit_valid, busy, done} streams are built from the job description.
module tb_pattern_tx;

    localparam int         PAT_W = 4;
    localparam logic [3:0] PAT   = 4'b1101;

    logic clk = 1'b0;
    logic n_rst = 1'b0;

    logic       start_a = 1'b0, abort_a = 1'b0;
    logic [3:0] rep_a = 4'd0;
    logic       o_a, bv_a, busy_a, done_a;
    logic       start_b = 1'b0, abort_b = 1'b0;
    logic [3:0] rep_b = 4'd0;
    logic       o_b, bv_b, busy_b, done_b;

    logic [3:0] obs_a, obs_b;
    assign obs_a = {o_a, bv_a, busy_a, done_a};
    assign obs_b = {o_b, bv_b, busy_b, done_b};

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    pattern_tx #(.PAT_W(4), .PATTERN(4'b1101), .GAP(1), .CNT_W(4)) dut_a (
        .clk(clk), .n_rst(n_rst), .start(start_a), .rep_count(rep_a), .abort(abort_a),
        .o(o_a), .bit_valid(bv_a), .busy(busy_a), .done(done_a)
    );

    pattern_tx #(.PAT_W(4), .PATTERN(4'b1101), .GAP(0), .CNT_W(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(start_b), .rep_count(rep_b), .abort(abort_b),
        .o(o_b), .bit_valid(bv_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Reference stream: each repetition is PAT_W valid bits, gaps between repetitions,
    // then one done cycle and idle.
    task automatic build_expected(input int rep, input int gap);
        exp_q.delete();
        for (int r = 0; r < rep; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({PAT[b], 3'b110});
            if (r < rep - 1) for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
    endtask

    task automatic drive(input bit sel, input logic s, input logic [3:0] r, input logic a);
        if (sel) begin
            start_b = s; rep_b = r; abort_b = a;
        end else begin
            start_a = s; rep_a = r; abort_a = a;
        end
    endtask

    function automatic logic [3:0] observe(input bit sel);
        return sel ? obs_b : obs_a;
    endfunction

    task automatic run_job(input bit sel, input int rep, input int abort_at, input int start_at,
                           input bit noisy, input string name);
        logic [3:0] exp;
        logic       s;
        logic       a;
        build_expected(rep, sel ? 0 : 1);
        @(negedge clk);
        drive(sel, 1'b1, rep[3:0], 1'b0);
        @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            exp = (abort_at >= 0 && i > abort_at) ? 4'b0000 : exp_q[i];
            checks++;
            if (observe(sel) !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: o/valid/busy/done got %b expected %b",
                         name, i, observe(sel), exp);
            end
            // Extra starts only land while busy or done, where they must be ignored.
            s = ((i == start_at) || (noisy && ($urandom_range(0, 1) == 1)))
                && (exp[1] || exp[0]) && (abort_at < 0 || i < abort_at);
            a = (i == abort_at) || (noisy && exp == 4'b0001);
            drive(sel, s, noisy ? 4'($urandom_range(0, 15)) : rep[3:0], a);
            @(negedge clk);
        end
        drive(sel, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_reset();
        start_a = 1'b1; rep_a = 4'd1;
        start_b = 1'b1; rep_b = 4'd1;
        #12;
        checks++;
        if (obs_a !== 4'b0000) begin
            errors++; $display("FAIL reset_a: got %b expected 0000", obs_a);
        end
        checks++;
        if (obs_b !== 4'b0000) begin
            errors++; $display("FAIL reset_b: got %b expected 0000", obs_b);
        end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_a !== 4'b0000 || obs_b !== 4'b0000) begin
            errors++; $display("FAIL reset_release: got %b %b expected 0000", obs_a, obs_b);
        end
    endtask

    task automatic test_single();
        run_job(0, 1, -1, -1, 0, "single");
    endtask

    task automatic test_gap_reps();
        run_job(0, 3, -1, -1, 0, "gap_rep3");
    endtask

    task automatic test_back_to_back();
        logic [3:0] hist;
        logic       det;
        hist = 4'b0000;
        build_expected(2, 0);
        @(negedge clk);
        drive(1, 1'b1, 4'd2, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, 4'd2, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_b !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b cycle %0d: got %b expected %b", i, obs_b, exp_q[i]);
            end
            // Ideal 1101 detector fed from o: fires on the current bit completing the pattern.
            hist = {hist[2:0], o_b};
            det  = bv_b && (hist == PAT);
            checks++;
            if (det !== (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL b2b_detect cycle %0d: got %b expected %b", i, det, (i == 3 || i == 7));
            end
            @(negedge clk);
        end
        run_job(1, 15, -1, -1, 1, "b2b_max");
    endtask

    task automatic test_zero_rep();
        run_job(0, 0, -1, -1, 0, "zero_rep_a");
        run_job(1, 0, -1, -1, 0, "zero_rep_b");
    endtask

    task automatic test_start_while_busy();
        run_job(0, 2, -1, 1, 0, "start_busy");
    endtask

    task automatic test_abort();
        run_job(0, 2, 2, -1, 0, "abort_bit3");
        run_job(0, 1, -1, -1, 0, "after_abort");
        run_job(0, 3, 4, -1, 0, "abort_gap");
        run_job(1, 2, 6, -1, 0, "abort_b2b");
    endtask

    task automatic test_abort_idle();
        @(negedge clk);
        drive(0, 1'b1, 4'd3, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_a !== 4'b0000) begin
                errors++; $display("FAIL abort_idle cycle %0d: got %b expected 0000", i, obs_a);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        build_expected(3, 1);
        @(negedge clk);
        drive(0, 1'b1, 4'd3, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 4'd3, 1'b0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        checks++;
        if (obs_a !== 4'b0010) begin
            errors++; $display("FAIL pre_reset_gap: got %b expected 0010", obs_a);
        end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (obs_a !== 4'b0000) begin
            errors++; $display("FAIL async_reset: got %b expected 0000", obs_a);
        end
        #1 n_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== 4'b0000) begin
                errors++; $display("FAIL post_reset_idle cycle %0d: got %b expected 0000", i, obs_a);
            end
        end
        run_job(0, 1, -1, -1, 0, "post_reset_job");
    endtask

    task automatic test_random();
        int sel, rep, blen, ab, gap;
        for (int j = 0; j < 24; j++) begin
            sel  = $urandom_range(0, 1);
            gap  = sel ? 0 : 1;
            rep  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
            blen = (rep == 0) ? 0 : rep * PAT_W + (rep - 1) * gap;
            ab   = (rep > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, blen - 1) : -1;
            run_job(sel[0], rep, ab, -1, 1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap_reps();
        test_back_to_back();
        test_zero_rep();
        test_start_while_busy();
        test_abort();
        test_abort_idle();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
